// File: rtl/dpram_pkg.sv
// -----------------------------------------------------------------------------
// dpram_pkg
// Shared definitions for the dpram_bypass RAM block: byte lane width, the
// controller state encoding, and the byte-merge / byte-parity helpers.
// The helpers work on a fixed maximum width; callers size-cast their operands
// in and the result back out, so one function serves every DATA_WIDTH up to
// MAX_DATA_W.
// -----------------------------------------------------------------------------
package dpram_pkg;

    localparam int BYTE_W     = 8;
    localparam int MAX_DATA_W = 256;
    localparam int MAX_BYTES  = MAX_DATA_W / BYTE_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Bytes selected by be come from new_word, the rest from old_word.
    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BYTES-1:0]  be
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_word;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (be[k]) begin
                res[k*BYTE_W +: BYTE_W] = new_word[k*BYTE_W +: BYTE_W];
            end
        end
        return res;
    endfunction

    // Even parity per byte: the stored bit makes the byte plus parity even.
    function automatic logic [MAX_BYTES-1:0] byte_parity(
        input logic [MAX_DATA_W-1:0] data
    );
        logic [MAX_BYTES-1:0] par;
        for (int k = 0; k < MAX_BYTES; k++) begin
            par[k] = ^data[k*BYTE_W +: BYTE_W];
        end
        return par;
    endfunction

endpackage

// File: rtl/dpram_out_pipe.sv
// -----------------------------------------------------------------------------
// dpram_out_pipe
// STAGES-deep delay line for read results {valid, err, data}. Valid resets to
// 0 so an asynchronous reset kills every result in flight. Err and data only
// advance alongside a valid, so the last stage holds its previous result while
// no new one is arriving. STAGES = 0 is a plain wire-through.
//
// Ports
//   clk      clock
//   rst_n    asynchronous active-low reset
//   d_valid  result valid entering the line
//   d_err    parity error flag of the entering result
//   d_data   data of the entering result
//   q_valid  result valid leaving the line
//   q_err    parity error flag leaving the line
//   q_data   data leaving the line (held while q_valid = 0)
// -----------------------------------------------------------------------------
module dpram_out_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  d_valid,
    input  logic                  d_err,
    input  logic [DATA_WIDTH-1:0] d_data,
    output logic                  q_valid,
    output logic                  q_err,
    output logic [DATA_WIDTH-1:0] q_data
);

    if (STAGES == 0) begin : g_bypass
        assign q_valid = d_valid;
        assign q_err   = d_err;
        assign q_data  = d_data;
    end else begin : g_stages
        logic [STAGES-1:0]     vld;
        logic [STAGES-1:0]     err;
        logic [DATA_WIDTH-1:0] dat [STAGES];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld <= '0;
                err <= '0;
                for (int s = 0; s < STAGES; s++) begin
                    dat[s] <= '0;
                end
            end else begin
                vld[0] <= d_valid;
                if (d_valid) begin
                    err[0] <= d_err;
                    dat[0] <= d_data;
                end
                for (int s = 1; s < STAGES; s++) begin
                    vld[s] <= vld[s-1];
                    if (vld[s-1]) begin
                        err[s] <= err[s-1];
                        dat[s] <= dat[s-1];
                    end
                end
            end
        end

        assign q_valid = vld[STAGES-1];
        assign q_err   = err[STAGES-1];
        assign q_data  = dat[STAGES-1];
    end

endmodule

// File: rtl/dpram_bypass.sv
// -----------------------------------------------------------------------------
// dpram_bypass
// Simple dual-port RAM (write port A, read port B, one clock) with per-byte
// write enables, write-first forwarding on same-address collisions, an
// OUT_DELAY-cycle read pipeline carrying a valid strobe, and a post-reset
// sequencer that zeroes every word before traffic is accepted.
//
// Optional feature macro: DPRAM_PARITY_EN
//   defined   - one even-parity bit per byte is stored and rechecked on read;
//               o_err_b flags a mismatch on any stored byte.
//   undefined - no parity storage, o_err_b is tied low.
//
// Ports
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset (memory contents not reset)
//   i_we_a       write strobe
//   i_be_a       byte enables, bit k covers data bits [8k+7:8k]
//   i_addr_a     write address
//   i_data_a     write data
//   i_en_b       read strobe
//   i_addr_b     read address
//   o_data_b     read data, meaningful while o_valid_b = 1
//   o_valid_b    read data valid, OUT_DELAY cycles after the read
//   o_err_b      parity error on the current read, qualified by o_valid_b
//   o_init_done  clear finished, RAM accepts traffic
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_CLEAR | writing zero to address clr_addr each cycle; port traffic ignored
// ST_RUN   | normal operation; terminal until the next reset
// -----------------------------------------------------------------------------
module dpram_bypass #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int RAM_DEPTH      = 1024,
    parameter int OUT_DELAY      = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_we_a,
    input  logic [DATA_WIDTH/8-1:0]    i_be_a,
    input  logic [ADDR_WIDTH-1:0]      i_addr_a,
    input  logic [DATA_WIDTH-1:0]      i_data_a,
    input  logic                       i_en_b,
    input  logic [ADDR_WIDTH-1:0]      i_addr_b,
    output logic [DATA_WIDTH-1:0]      o_data_b,
    output logic                       o_valid_b,
    output logic                       o_err_b,
    output logic                       o_init_done
);

    import dpram_pkg::*;

    localparam int NB       = DATA_WIDTH / BYTE_W;
    localparam int IDX_W    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam bit FULL_MAP = (RAM_DEPTH >= (1 << ADDR_WIDTH));

    state_t              state;
    state_t              state_nxt;
    logic [IDX_W-1:0]    clr_addr;
    logic                clr_last;
    logic                init_done;

    logic                wr_ok;
    logic                rd_ok;
    logic                mem_we;
    logic [NB-1:0]       mem_be;
    logic [IDX_W-1:0]    mem_idx;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                rd_issue;
    logic [IDX_W-1:0]    rd_idx;
    logic [DATA_WIDTH-1:0] rd_raw;

    logic                rd_hit;
    logic [NB-1:0]       fwd_be;
    logic [DATA_WIDTH-1:0] s1_data_nxt;
    logic                s1_err_nxt;
    logic                s1_valid;
    logic                s1_err;
    logic [DATA_WIDTH-1:0] s1_data;

    // Address range check. When the address space maps exactly onto the
    // array every address is legal, and a compare would be constant.
    if (FULL_MAP) begin : g_full_map
        assign wr_ok = 1'b1;
        assign rd_ok = 1'b1;
    end else begin : g_part_map
        localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(RAM_DEPTH);
        assign wr_ok = (i_addr_a < DEPTH_A);
        assign rd_ok = (i_addr_b < DEPTH_A);
    end

    assign clr_last = (clr_addr == IDX_W'(RAM_DEPTH - 1));
    assign rd_idx   = i_addr_b[IDX_W-1:0];

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (clr_last) state_nxt = ST_RUN;
            ST_RUN:   state_nxt = ST_RUN;
            default:  state_nxt = state;
        endcase
    end

    // Output logic: selects who owns the write port and whether reads issue.
    always_comb begin
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_idx   = '0;
        mem_wdata = '0;
        rd_issue  = 1'b0;
        case (state)
            ST_CLEAR: begin
                mem_we  = 1'b1;
                mem_be  = '1;
                mem_idx = clr_addr;
            end
            ST_RUN: begin
                mem_we    = i_we_a && wr_ok && (i_be_a != '0);
                mem_be    = i_be_a;
                mem_idx   = i_addr_a[IDX_W-1:0];
                mem_wdata = i_data_a;
                rd_issue  = i_en_b;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clr_addr  <= '0;
            init_done <= 1'b0;
        end else begin
            if (state == ST_CLEAR && !clr_last) begin
                clr_addr <= clr_addr + 1'b1;
            end
            // Registered from the state so done trails the last clear write.
            init_done <= (state == ST_RUN);
        end
    end

`ifdef DPRAM_PARITY_EN
    logic [NB-1:0] wr_par;
    logic [NB-1:0] rd_par;
    logic [NB-1:0] rd_par_calc;

    assign wr_par = NB'(byte_parity(MAX_DATA_W'(mem_wdata)));
`endif

    // One RAM per byte lane so byte enables map onto independent arrays.
    for (genvar k = 0; k < NB; k++) begin : g_lane
        logic [BYTE_W-1:0] mem [RAM_DEPTH];

        always_ff @(posedge i_clk) begin
            if (mem_we && mem_be[k]) begin
                mem[mem_idx] <= mem_wdata[k*BYTE_W +: BYTE_W];
            end
        end

        assign rd_raw[k*BYTE_W +: BYTE_W] = mem[rd_idx];

`ifdef DPRAM_PARITY_EN
        logic par [RAM_DEPTH];

        always_ff @(posedge i_clk) begin
            if (mem_we && mem_be[k]) begin
                par[mem_idx] <= wr_par[k];
            end
        end

        assign rd_par[k] = par[rd_idx];
`endif
    end

    // Write-first forwarding: bytes being written this cycle to the address
    // being read replace the stored bytes. mem_we already implies RUN and an
    // in-range write address, so equal addresses also mean an in-range read.
    assign rd_hit      = mem_we && (i_addr_a == i_addr_b);
    assign fwd_be      = rd_hit ? i_be_a : '0;
    assign s1_data_nxt = rd_ok
        ? DATA_WIDTH'(byte_merge(MAX_DATA_W'(rd_raw), MAX_DATA_W'(i_data_a),
                                 MAX_BYTES'(fwd_be)))
        : '0;

`ifdef DPRAM_PARITY_EN
    // Forwarded bytes never touched the array, so only stored bytes are checked.
    assign rd_par_calc = NB'(byte_parity(MAX_DATA_W'(rd_raw)));
    assign s1_err_nxt  = rd_ok && (|((rd_par_calc ^ rd_par) & ~fwd_be));
`else
    assign s1_err_nxt  = 1'b0;
`endif

    // Stage 1: RAM output register with the forwarding merge folded in.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_issue;
            if (rd_issue) begin
                s1_err  <= s1_err_nxt;
                s1_data <= s1_data_nxt;
            end
        end
    end

    dpram_out_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .STAGES     (OUT_DELAY - 1)
    ) u_out_pipe (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .d_valid (s1_valid),
        .d_err   (s1_err),
        .d_data  (s1_data),
        .q_valid (o_valid_b),
        .q_err   (o_err_b),
        .q_data  (o_data_b)
    );

    assign o_init_done = init_done;

endmodule

// File: tb/tb_dpram_bypass.sv
// -----------------------------------------------------------------------------
// tb_dpram_bypass
// Directed bench for dpram_bypass. Instance dut: 16 words, 5-bit addresses,
// OUT_DELAY = 3, clear on reset. Instance dut1: same geometry, OUT_DELAY = 1,
// no clear. Inputs change 1 ns after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_dpram_bypass;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 16;
    localparam int DLY   = 3;

    logic          clk = 1'b0;
    logic          rst_n;

    logic          we_a, en_b;
    logic [3:0]    be_a;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_a, data_b;
    logic          valid_b, err_b, init_done;

    logic          we_a1, en_b1;
    logic [3:0]    be_a1;
    logic [AW-1:0] addr_a1, addr_b1;
    logic [DW-1:0] data_a1, data_b1;
    logic          valid_b1, err_b1, init_done1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] ord_exp [4];

    always #5 clk = ~clk;

    dpram_bypass #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH),
        .OUT_DELAY(DLY), .CLEAR_ON_RESET(1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_we_a(we_a), .i_be_a(be_a), .i_addr_a(addr_a), .i_data_a(data_a),
        .i_en_b(en_b), .i_addr_b(addr_b),
        .o_data_b(data_b), .o_valid_b(valid_b), .o_err_b(err_b),
        .o_init_done(init_done)
    );

    dpram_bypass #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH),
        .OUT_DELAY(1), .CLEAR_ON_RESET(0)
    ) dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_we_a(we_a1), .i_be_a(be_a1), .i_addr_a(addr_a1), .i_data_a(data_a1),
        .i_en_b(en_b1), .i_addr_b(addr_b1),
        .o_data_b(data_b1), .o_valid_b(valid_b1), .o_err_b(err_b1),
        .o_init_done(init_done1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        we_a   = 1'b1;
        addr_a = a;
        data_a = d;
        be_a   = be;
        tick();
        we_a   = 1'b0;
        be_a   = 4'b0000;
    endtask

    // Single read on dut: no valid before OUT_DELAY cycles, then data and err.
    task automatic rd_chk(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                          input logic exp_err, input string tag);
        en_b   = 1'b1;
        addr_b = a;
        tick();
        en_b   = 1'b0;
        for (int k = 1; k < DLY; k++) begin
            chk_bit({tag, "_early"}, valid_b, 1'b0);
            tick();
        end
        chk_bit({tag, "_vld"}, valid_b, 1'b1);
        chk({tag, "_data"}, data_b, exp);
        chk_bit({tag, "_err"}, err_b, exp_err);
    endtask

    initial begin
        rst_n  = 1'b0;
        we_a   = 1'b0; be_a  = 4'b0000; addr_a  = '0; data_a  = '0; en_b  = 1'b0; addr_b  = '0;
        we_a1  = 1'b0; be_a1 = 4'b0000; addr_a1 = '0; data_a1 = '0; en_b1 = 1'b0; addr_b1 = '0;
        ord_exp = '{32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hC2C2_C2C2, 32'hD3D3_D3D3};

        repeat (3) tick();
        chk_bit("rst_valid", valid_b, 1'b0);
        chk("rst_data", data_b, 32'h0);
        chk_bit("rst_err", err_b, 1'b0);
        chk_bit("rst_init", init_done, 1'b0);
        chk_bit("rst_init_noclr", init_done1, 1'b0);
        chk_bit("rst_valid_noclr", valid_b1, 1'b0);

        // Clear: reads and writes offered during the clear must be ignored.
        rst_n  = 1'b1;
        en_b   = 1'b1;
        addr_b = '0;
        for (int c = 1; c <= DEPTH + 1; c++) begin
            if (c == 2) begin
                we_a = 1'b1; be_a = 4'b1111; addr_a = '0; data_a = 32'hFFFF_FFFF;
            end
            if (c == 11) begin
                we_a = 1'b0; be_a = 4'b0000; en_b = 1'b0;
            end
            tick();
            if (c == 1) chk_bit("noclr_init_1cyc", init_done1, 1'b1);
            if (c <= DEPTH) begin
                chk_bit("clr_busy", init_done, 1'b0);
                chk_bit("clr_no_read", valid_b, 1'b0);
            end
        end
        chk_bit("clr_done_17", init_done, 1'b1);
        chk_bit("clr_no_stale", valid_b, 1'b0);

        // Every word reads back zero, back to back, one result per cycle.
        for (int i = 0; i < DEPTH + DLY - 1; i++) begin
            if (i < DEPTH) begin
                en_b = 1'b1; addr_b = AW'(i);
            end else begin
                en_b = 1'b0;
            end
            tick();
            if (i >= DLY - 1) begin
                chk_bit("sweep_vld", valid_b, 1'b1);
                chk("sweep_data", data_b, 32'h0);
                chk_bit("sweep_err", err_b, 1'b0);
            end
        end
        tick();
        chk_bit("sweep_drain", valid_b, 1'b0);

        // Byte-enable merge.
        wr(5'd5, 32'hAABB_CCDD, 4'b1111);
        wr(5'd5, 32'h1122_3344, 4'b0101);
        rd_chk(5'd5, 32'hAA22_CC44, 1'b0, "merge");

        // Same-cycle write and read to one address: write-first per byte.
        wr(5'd3, 32'h1234_5678, 4'b1111);
        we_a = 1'b1; addr_a = 5'd3; data_a = 32'hDEAD_BEEF; be_a = 4'b1100;
        en_b = 1'b1; addr_b = 5'd3;
        tick();
        we_a = 1'b0; be_a = 4'b0000; en_b = 1'b0;
        chk_bit("coll_early0", valid_b, 1'b0);
        tick();
        chk_bit("coll_early1", valid_b, 1'b0);
        tick();
        chk_bit("coll_vld", valid_b, 1'b1);
        chk("coll_data", data_b, 32'hDEAD_5678);
        rd_chk(5'd3, 32'hDEAD_5678, 1'b0, "coll_stored");

        // Four consecutive reads come out in order, three cycles later.
        wr(5'd0, 32'hA0A0_A0A0, 4'b1111);
        wr(5'd1, 32'hB1B1_B1B1, 4'b1111);
        wr(5'd2, 32'hC2C2_C2C2, 4'b1111);
        wr(5'd3, 32'hD3D3_D3D3, 4'b1111);
        for (int i = 0; i < 7; i++) begin
            if (i < 4) begin
                en_b = 1'b1; addr_b = AW'(i);
            end else begin
                en_b = 1'b0;
            end
            tick();
            if (i < 2) begin
                chk_bit("ord_early", valid_b, 1'b0);
            end else if (i < 6) begin
                chk_bit("ord_vld", valid_b, 1'b1);
                chk("ord_data", data_b, ord_exp[i-2]);
            end else begin
                chk_bit("ord_end", valid_b, 1'b0);
                chk("ord_hold", data_b, 32'hD3D3_D3D3);
            end
        end

        // Out-of-range and zero-enable writes are dropped; out-of-range read is 0.
        wr(5'd4,  32'h4444_4444, 4'b1111);
        wr(5'd20, 32'hEEEE_EEEE, 4'b1111);
        wr(5'd4,  32'hFFFF_FFFF, 4'b0000);
        rd_chk(5'd20, 32'h0, 1'b0, "oor_read");
        rd_chk(5'd4, 32'h4444_4444, 1'b0, "oor_keep");

`ifdef DPRAM_PARITY_EN
        wr(5'd7, 32'h0F0F_0F0F, 4'b1111);
        rd_chk(5'd7, 32'h0F0F_0F0F, 1'b0, "par_clean");
        dut.g_lane[1].mem[7][0] = ~dut.g_lane[1].mem[7][0];
        rd_chk(5'd7, 32'h0F0F_0E0F, 1'b1, "par_flip");
`endif

        // Latency-1 instance without clear.
        we_a1 = 1'b1; addr_a1 = 5'd2; data_a1 = 32'h1357_9BDF; be_a1 = 4'b1111;
        tick();
        we_a1 = 1'b0; be_a1 = 4'b0000;
        en_b1 = 1'b1; addr_b1 = 5'd2;
        tick();
        en_b1 = 1'b0;
        chk_bit("d1_vld", valid_b1, 1'b1);
        chk("d1_data", data_b1, 32'h1357_9BDF);
        we_a1 = 1'b1; addr_a1 = 5'd2; data_a1 = 32'h0000_AAAA; be_a1 = 4'b0011;
        en_b1 = 1'b1; addr_b1 = 5'd2;
        tick();
        we_a1 = 1'b0; be_a1 = 4'b0000; en_b1 = 1'b0;
        chk_bit("d1_coll_vld", valid_b1, 1'b1);
        chk("d1_coll_data", data_b1, 32'h1357_AAAA);
        tick();
        chk_bit("d1_idle", valid_b1, 1'b0);
        chk("d1_hold", data_b1, 32'h1357_AAAA);
        en_b1 = 1'b1; addr_b1 = 5'd20;
        tick();
        en_b1 = 1'b0;
        chk_bit("d1_oor_vld", valid_b1, 1'b1);
        chk("d1_oor_data", data_b1, 32'h0);

        // Reset with two reads still in flight.
        en_b = 1'b1; addr_b = 5'd5;
        repeat (3) tick();
        en_b = 1'b0;
        chk_bit("inflight_vld", valid_b, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_bit("arst_valid", valid_b, 1'b0);
        chk("arst_data", data_b, 32'h0);
        chk_bit("arst_init", init_done, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int c = 1; c <= DEPTH + 1; c++) begin
            tick();
            chk_bit("rerun_no_stale", valid_b, 1'b0);
        end
        chk_bit("reclr_done", init_done, 1'b1);
        rd_chk(5'd5, 32'h0, 1'b0, "reclr_zero");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
